// File: rtl/mc_cu_pkg.sv
// Shared encodings for the multi-cycle control unit: states, ALU/mux codes,
// opcode/func values and the one-hot instruction class produced by the decoder.
package mc_cu_pkg;

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EXE = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_e;

    localparam logic [3:0] ALUC_ADD = 4'b0000;
    localparam logic [3:0] ALUC_SUB = 4'b0100;
    localparam logic [3:0] ALUC_AND = 4'b0001;
    localparam logic [3:0] ALUC_OR  = 4'b0101;
    localparam logic [3:0] ALUC_XOR = 4'b0010;
    localparam logic [3:0] ALUC_LUI = 4'b0110;
    localparam logic [3:0] ALUC_SLL = 4'b0011;
    localparam logic [3:0] ALUC_SRL = 4'b0111;
    localparam logic [3:0] ALUC_SRA = 4'b1111;
    localparam logic [3:0] ALUC_BLE = 4'b1011;

    localparam logic [1:0] PC_ALU    = 2'd0;
    localparam logic [1:0] PC_ALUOUT = 2'd1;
    localparam logic [1:0] PC_REGA   = 2'd2;
    localparam logic [1:0] PC_JUMP   = 2'd3;

    localparam logic [1:0] ALUA_PC   = 2'd0;
    localparam logic [1:0] ALUA_REGA = 2'd1;
    localparam logic [1:0] ALUA_SA   = 2'd2;

    localparam logic [1:0] ALUB_REGB = 2'd0;
    localparam logic [1:0] ALUB_FOUR = 2'd1;
    localparam logic [1:0] ALUB_IMM  = 2'd2;
    localparam logic [1:0] ALUB_BR   = 2'd3;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_BLE   = 6'b000110;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_XOR = 6'b100110;
    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_SRL = 6'b000010;
    localparam logic [5:0] FN_SRA = 6'b000011;
    localparam logic [5:0] FN_JR  = 6'b001000;

    typedef struct packed {
        logic i_add, i_sub, i_and, i_or, i_xor;
        logic i_sll, i_srl, i_sra, i_jr;
        logic i_addi, i_andi, i_ori, i_xori, i_lui;
        logic i_lw, i_sw, i_beq, i_bne, i_ble;
        logic i_j, i_jal;
    } inst_t;

    // Immediate forms share the code of their R-type counterpart.
    function automatic logic [3:0] aluc_of(input inst_t c);
        if (c.i_sub || c.i_beq || c.i_bne) return ALUC_SUB;
        if (c.i_and || c.i_andi)           return ALUC_AND;
        if (c.i_or  || c.i_ori)            return ALUC_OR;
        if (c.i_xor || c.i_xori)           return ALUC_XOR;
        if (c.i_lui)                       return ALUC_LUI;
        if (c.i_sll)                       return ALUC_SLL;
        if (c.i_srl)                       return ALUC_SRL;
        if (c.i_sra)                       return ALUC_SRA;
        if (c.i_ble)                       return ALUC_BLE;
        return ALUC_ADD;
    endfunction

endpackage

// File: rtl/mc_cu_dec.sv
// Combinational instruction decoder: op/func to one-hot class; any encoding
// outside the supported set raises illegal.
module mc_cu_dec
    import mc_cu_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] func,
    output inst_t      cls,
    output logic       illegal
);

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        cls = '0;
        case (op)
            OP_RTYPE: begin
                case (func)
                    FN_ADD:  cls.i_add = 1'b1;
                    FN_SUB:  cls.i_sub = 1'b1;
                    FN_AND:  cls.i_and = 1'b1;
                    FN_OR:   cls.i_or  = 1'b1;
                    FN_XOR:  cls.i_xor = 1'b1;
                    FN_SLL:  cls.i_sll = 1'b1;
                    FN_SRL:  cls.i_srl = 1'b1;
                    FN_SRA:  cls.i_sra = 1'b1;
                    FN_JR:   cls.i_jr  = 1'b1;
                    default: cls = '0;
                endcase
            end
            OP_ADDI: cls.i_addi = 1'b1;
            OP_ANDI: cls.i_andi = 1'b1;
            OP_ORI:  cls.i_ori  = 1'b1;
            OP_XORI: cls.i_xori = 1'b1;
            OP_LUI:  cls.i_lui  = 1'b1;
            OP_LW:   cls.i_lw   = 1'b1;
            OP_SW:   cls.i_sw   = 1'b1;
            OP_BEQ:  cls.i_beq  = 1'b1;
            OP_BNE:  cls.i_bne  = 1'b1;
            OP_BLE:  cls.i_ble  = 1'b1;
            OP_J:    cls.i_j    = 1'b1;
            OP_JAL:  cls.i_jal  = 1'b1;
            default: cls = '0;
        endcase
    end

    assign illegal = (cls == '0);

endmodule

// File: rtl/mc_cu.sv
// Multi-cycle MIPS-subset control FSM (IF/ID/EXE/MEM/WB) with memory-ready
// handshake and a retired-instruction counter.
module mc_cu
    import mc_cu_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic [5:0]       op,
    input  logic [5:0]       func,
    input  logic             z,
    input  logic             le,
    input  logic             mem_ready,
    output logic             rmem,
    output logic             wmem,
    output logic             iord,
    output logic             wir,
    output logic             wpc,
    output logic [1:0]       pcsource,
    output logic [1:0]       alua_sel,
    output logic [1:0]       alub_sel,
    output logic [3:0]       aluc,
    output logic             sext,
    output logic             wreg,
    output logic             regrt,
    output logic             m2reg,
    output logic             jal,
    output logic [2:0]       state,
    output logic             illegal,
    output logic [CNT_W-1:0] icount
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] icount_q, icount_d;
    logic             retire;
    inst_t            cls;
    logic             dec_illegal;
    logic             is_ralu, is_shift, is_ialu, is_branch, taken;

    mc_cu_dec u_dec (
        .op      (op),
        .func    (func),
        .cls     (cls),
        .illegal (dec_illegal)
    );

    assign is_ralu   = cls.i_add | cls.i_sub | cls.i_and | cls.i_or | cls.i_xor;
    assign is_shift  = cls.i_sll | cls.i_srl | cls.i_sra;
    assign is_ialu   = cls.i_addi | cls.i_andi | cls.i_ori | cls.i_xori | cls.i_lui;
    assign is_branch = cls.i_beq | cls.i_bne | cls.i_ble;
    assign taken     = (cls.i_beq & z) | (cls.i_bne & ~z) | (cls.i_ble & le);

    // NOTE: sequential state uses non-blocking assignments; reset is asynchronous active-low.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IF;
            icount_q <= '0;
        end else begin
            state_q  <= state_d;
            icount_q <= icount_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        retire   = 1'b0;
        rmem     = 1'b0;
        wmem     = 1'b0;
        iord     = 1'b0;
        wir      = 1'b0;
        wpc      = 1'b0;
        pcsource = PC_ALU;
        alua_sel = ALUA_PC;
        alub_sel = ALUB_REGB;
        aluc     = ALUC_ADD;
        sext     = 1'b0;
        wreg     = 1'b0;
        regrt    = 1'b0;
        m2reg    = 1'b0;
        jal      = 1'b0;
        illegal  = 1'b0;
        // Holding reset silences every control line, including pending memory requests.
        if (resetn) begin
            case (state_q)
                S_IF: begin
                    rmem     = 1'b1;
                    alub_sel = ALUB_FOUR;
                    if (mem_ready) begin
                        wir     = 1'b1;
                        wpc     = 1'b1;
                        state_d = S_ID;
                    end
                end
                S_ID: begin
                    alub_sel = ALUB_BR;
                    sext     = 1'b1;
                    if (cls.i_j || cls.i_jal) begin
                        wpc      = 1'b1;
                        pcsource = PC_JUMP;
                        wreg     = cls.i_jal;
                        jal      = cls.i_jal;
                        retire   = 1'b1;
                        state_d  = S_IF;
                    end else if (cls.i_jr) begin
                        wpc      = 1'b1;
                        pcsource = PC_REGA;
                        retire   = 1'b1;
                        state_d  = S_IF;
                    end else if (dec_illegal) begin
                        illegal  = 1'b1;
                        retire   = 1'b1;
                        state_d  = S_IF;
                    end else begin
                        state_d  = S_EXE;
                    end
                end
                S_EXE: begin
                    alua_sel = ALUA_REGA;
                    aluc     = aluc_of(cls);
                    state_d  = S_IF;
                    if (is_ralu) begin
                        state_d = S_WB;
                    end else if (is_shift) begin
                        alua_sel = ALUA_SA;
                        state_d  = S_WB;
                    end else if (is_ialu) begin
                        alub_sel = ALUB_IMM;
                        sext     = cls.i_addi;
                        state_d  = S_WB;
                    end else if (cls.i_lw || cls.i_sw) begin
                        alub_sel = ALUB_IMM;
                        sext     = 1'b1;
                        state_d  = S_MEM;
                    end else if (is_branch) begin
                        wpc      = taken;
                        pcsource = taken ? PC_ALUOUT : PC_ALU;
                        retire   = 1'b1;
                    end
                end
                S_MEM: begin
                    iord = 1'b1;
                    rmem = cls.i_lw;
                    wmem = cls.i_sw;
                    if (mem_ready) begin
                        if (cls.i_lw) begin
                            state_d = S_WB;
                        end else begin
                            retire  = cls.i_sw;
                            state_d = S_IF;
                        end
                    end
                end
                S_WB: begin
                    wreg    = 1'b1;
                    regrt   = is_ialu | cls.i_lw;
                    m2reg   = cls.i_lw;
                    retire  = 1'b1;
                    state_d = S_IF;
                end
                default: state_d = S_IF;
            endcase
        end
    end

    assign icount_d = icount_q + {{(CNT_W-1){1'b0}}, retire};
    assign icount   = icount_q;
    assign state    = state_q;

endmodule
